// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - triggered pre/post capture of one ADC channel into a circular sample RAM
module adc_capture_sequencer #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        csr_address,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic              snk_valid,
  input  logic [CH_W-1:0]   snk_channel,
  input  logic [DATA_W-1:0] snk_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              complete
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_level;
  logic [CH_W-1:0]     r_chan;
  logic [ADDR_W-1:0]   r_pre;
  logic [ADDR_W-1:0]   r_post;
  logic                r_l_slope;
  logic [DATA_W-1:0]   r_l_level;
  logic [CH_W-1:0]     r_l_chan;
  logic [ADDR_W-1:0]   r_l_pre;
  logic [ADDR_W-1:0]   r_l_post;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_prev;
  logic                r_prev_valid;
  logic                r_force_pend;
  logic                r_wrapped;

  logic w_ctl_wr, w_arm, w_abort, w_force;
  logic w_qual, w_capturing, w_store, w_waiting;
  logic w_rise, w_fall, w_cross, w_trig;
  logic w_unused_wdata;

  assign w_ctl_wr    = csr_write && (csr_address == 3'd0);
  assign w_arm       = w_ctl_wr && csr_writedata[0];
  assign w_abort     = w_ctl_wr && csr_writedata[1];
  assign w_force     = w_ctl_wr && csr_writedata[3];
  assign w_qual      = snk_valid && (snk_channel == r_l_chan);
  assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_store     = w_qual && w_capturing;
  // A zero pre-trigger count means the very first sample is already a trigger candidate.
  assign w_waiting   = (r_state == S_WAIT) || ((r_state == S_PRE) && (r_l_pre == '0));
  assign w_rise      = r_prev_valid && (r_prev < r_l_level) && (snk_data >= r_l_level);
  assign w_fall      = r_prev_valid && (r_prev > r_l_level) && (snk_data <= r_l_level);
  assign w_cross     = r_l_slope ? w_fall : w_rise;
  assign w_trig      = w_store && w_waiting && (r_force_pend || w_cross);
  assign w_unused_wdata = ^csr_writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_level      <= '0;
      r_chan       <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      r_l_slope    <= 1'b0;
      r_l_level    <= '0;
      r_l_chan     <= '0;
      r_l_pre      <= '0;
      r_l_post     <= '0;
      r_waddr      <= '0;
      r_trig_addr  <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_force_pend <= 1'b0;
      r_wrapped    <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      complete     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (csr_write) begin
        case (csr_address)
          3'd2:    r_level <= csr_writedata[DATA_W-1:0];
          3'd3:    r_chan  <= csr_writedata[CH_W-1:0];
          3'd4:    r_pre   <= csr_writedata[ADDR_W-1:0];
          3'd5:    r_post  <= csr_writedata[ADDR_W-1:0];
          default: ;
        endcase
      end

      if (w_abort) begin
        r_state      <= S_IDLE;
        complete     <= 1'b0;
        r_force_pend <= 1'b0;
      end else if (w_arm && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
        r_l_slope    <= csr_writedata[2];
        r_l_level    <= r_level;
        r_l_chan     <= r_chan;
        r_l_pre      <= r_pre;
        r_l_post     <= r_post;
        r_waddr      <= '0;
        r_wrapped    <= 1'b0;
        r_cnt        <= '0;
        r_prev_valid <= 1'b0;
        r_force_pend <= 1'b0;
        complete     <= 1'b0;
        r_state      <= S_PRE;
      end else begin
        if (w_force && ((r_state == S_PRE) || (r_state == S_WAIT)))
          r_force_pend <= 1'b1;

        if (w_store) begin
          mem_we       <= 1'b1;
          mem_waddr    <= r_waddr;
          mem_wdata    <= snk_data;
          r_waddr      <= r_waddr + 1'b1;
          r_prev       <= snk_data;
          r_prev_valid <= 1'b1;
          if (&r_waddr)
            r_wrapped <= 1'b1;
        end

        case (r_state)
          S_PRE: begin
            if (r_l_pre == '0) begin
              r_state <= S_WAIT;
            end else if (w_store) begin
              if (r_cnt == r_l_pre - 1'b1) begin
                r_state <= S_WAIT;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          S_POST: begin
            if (w_store) begin
              if (r_cnt == r_l_post - 1'b1) begin
                r_state  <= S_DONE;
                complete <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase

        // Trigger overrides the PRE->WAIT step when both land on the same sample.
        if (w_trig) begin
          r_trig_addr  <= r_waddr;
          r_force_pend <= 1'b0;
          r_cnt        <= '0;
          if (r_l_post == '0) begin
            r_state  <= S_DONE;
            complete <= 1'b1;
          end else begin
            r_state <= S_POST;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      case (csr_address)
        3'd1:    csr_readdata <= {26'd0, r_wrapped, complete, 1'b0, r_state};
        3'd2:    csr_readdata <= 32'(r_level);
        3'd3:    csr_readdata <= 32'(r_chan);
        3'd4:    csr_readdata <= 32'(r_pre);
        3'd5:    csr_readdata <= 32'(r_post);
        3'd6:    csr_readdata <= 32'(r_trig_addr);
        3'd7:    csr_readdata <= 32'(r_waddr);
        default: csr_readdata <= '0;
      endcase
    end else begin
      csr_readdata <= '0;
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb/tb_adc_capture_sequencer.sv - directed and randomized captures checked against a reference model
module tb_adc_capture_sequencer;
  localparam int DW = 12;
  localparam int AW = 4;
  localparam int CW = 5;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    csr_address = '0;
  logic          csr_write = 1'b0;
  logic          csr_read = 1'b0;
  logic [31:0]   csr_writedata = '0;
  logic [31:0]   csr_readdata;
  logic          snk_valid = 1'b0;
  logic [CW-1:0] snk_channel = '0;
  logic [DW-1:0] snk_data = '0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          complete;

  adc_capture_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .snk_valid(snk_valid), .snk_channel(snk_channel), .snk_data(snk_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .complete(complete)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int q[$];
  int c_ch, c_level, c_pre, c_post, c_slope, c_force;
  int m_n, m_trig, m_done, m_state;
  int rd;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(int'(mem_waddr));
      wd_q.push_back(int'(mem_wdata));
      wc_q.push_back(int'(complete));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input int a, input int d);
    csr_address = 3'(a); csr_writedata = 32'(d); csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input int a, output int d);
    csr_address = 3'(a); csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = int'(csr_readdata);
  endtask

  task automatic drive(input int ch, input int d);
    snk_valid = 1'b1; snk_channel = CW'(ch); snk_data = DW'(d);
    @(posedge clk); #1;
    snk_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bit crosses(input int p, input int c);
    if (c_slope != 0) return (p > c_level) && (c <= c_level);
    return (p < c_level) && (c >= c_level);
  endfunction

  // Reference: walk the qualified samples applying the capture rules directly.
  function automatic void model();
    int pre  = c_pre % DEPTH;
    int post = c_post % DEPTH;
    m_n = 0; m_trig = -1; m_done = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (m_done != 0) break;
      m_n++;
      if (m_trig < 0) begin
        if (i >= pre && ((c_force != 0 && i == pre) || (i > 0 && crosses(q[i-1], q[i])))) begin
          m_trig = i;
          if (post == 0) m_done = 1;
        end
      end else if (i == m_trig + post) begin
        m_done = 1;
      end
    end
    if (m_done != 0)     m_state = 4;
    else if (m_trig >= 0) m_state = 3;
    else if (m_n >= pre) m_state = 2;
    else                 m_state = 1;
  endfunction

  task automatic run_capture(input int noise);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    csr_wr(2, c_level); csr_wr(3, c_ch); csr_wr(4, c_pre); csr_wr(5, c_post);
    csr_wr(0, 1 | (c_slope << 2));
    if (c_force != 0) csr_wr(0, 8);
    for (int i = 0; i < q.size(); i++) begin
      if (noise != 0) begin
        int k = int'($urandom_range(0, 2));
        for (int j = 0; j < k; j++) begin
          if ($urandom_range(0, 1) == 1)
            drive((c_ch + 1 + int'($urandom_range(0, 30))) % 32, int'($urandom_range(0, 4095)));
          else
            idle(1);
        end
      end
      drive(c_ch, q[i]);
    end
    idle(3);
  endtask

  task automatic check_capture(input string tag);
    int st, bad;
    model();
    check({tag, "/nwr"}, wa_q.size(), m_n);
    for (int k = 0; k < m_n && k < wa_q.size(); k++) begin
      check($sformatf("%s/addr%0d", tag, k), wa_q[k], k % DEPTH);
      check($sformatf("%s/data%0d", tag, k), wd_q[k], q[k]);
    end
    bad = 0;
    for (int k = 0; k + 1 < wc_q.size(); k++) bad += wc_q[k];
    check({tag, "/early_complete"}, bad, 0);
    if (wc_q.size() > 0) check({tag, "/complete_last_wr"}, wc_q[wc_q.size()-1], m_done);
    check({tag, "/complete_pin"}, int'(complete), m_done);
    csr_rd(1, st);
    check({tag, "/state"}, st & 7, m_state);
    check({tag, "/st_complete"}, (st >> 4) & 1, m_done);
    check({tag, "/wrapped"}, (st >> 5) & 1, (m_n >= DEPTH) ? 1 : 0);
    if (m_trig >= 0) begin
      csr_rd(6, st);
      check({tag, "/trig_addr"}, st, m_trig % DEPTH);
    end
    csr_rd(7, st);
    check({tag, "/wr_addr"}, st, m_n % DEPTH);
    if (m_state != 4) csr_wr(0, 2);
  endtask

  initial begin
    idle(4);
    reset = 1'b0;
    idle(1);

    // reset state
    for (int a = 0; a < 8; a++) begin
      csr_rd(a, rd);
      check($sformatf("reset/reg%0d", a), rd, 0);
    end
    check("reset/complete", int'(complete), 0);
    check("reset/mem_waddr", int'(mem_waddr), 0);
    check("reset/no_writes", wa_q.size(), 0);
    csr_wr(2, 'hABC);
    csr_rd(2, rd);
    check("level_readback", rd, 'hABC);

    // rising ramp crossing 0x7FC -> 0x800 with channel noise
    c_ch = 3; c_level = 'h800; c_pre = 4; c_post = 8; c_slope = 0; c_force = 0;
    q.delete();
    for (int k = 0; k < 16; k++) q.push_back('h7F0 + 4 * k);
    run_capture(1);
    check_capture("ramp");
    check("ramp/nwr13", wa_q.size(), 13);

    // falling, zero post count; armed straight from DONE
    c_level = 'h100; c_pre = 0; c_post = 0; c_slope = 1;
    q = '{'h200, 'h180, 'h100, 'h080};
    run_capture(0);
    check_capture("fall");

    // forced trigger on constant input
    c_level = 'h800; c_pre = 0; c_post = 2; c_slope = 0; c_force = 1;
    q = '{'h555, 'h555, 'h555, 'h555, 'h555, 'h555};
    run_capture(1);
    check_capture("force");
    c_force = 0;

    // wraparound: PRE_COUNT field is 4 bits wide here
    c_level = 'h400; c_pre = 20; c_post = 3; c_slope = 0;
    q.delete();
    for (int k = 0; k < 24; k++) q.push_back(int'($urandom_range(0, 'h3FF)));
    q.push_back('h7FF);
    for (int k = 0; k < 5; k++) q.push_back(int'($urandom_range(0, 4095)));
    run_capture(1);
    check_capture("wrap");

    // ABORT during POST after two post-trigger writes
    c_level = 'h800; c_pre = 1; c_post = 8;
    q = '{'h100, 'h900, 'h900, 'h900};
    run_capture(0);
    check_capture("abort");
    for (int k = 0; k < 3; k++) drive(c_ch, 'h900);
    idle(2);
    check("abort/no_more_writes", wa_q.size(), 4);
    csr_rd(1, rd);
    check("abort/status", rd, 0);
    check("abort/complete_pin", int'(complete), 0);

    // ARM and ABORT in one write
    csr_wr(0, 3);
    for (int k = 0; k < 3; k++) drive(c_ch, 'h900);
    idle(2);
    check("armabort/no_writes", wa_q.size(), 4);
    csr_rd(1, rd);
    check("armabort/status", rd, 0);

    // randomized captures
    for (int t = 0; t < 6; t++) begin
      int v;
      c_ch = int'($urandom_range(0, 31));
      c_level = int'($urandom_range(200, 3800));
      c_pre = int'($urandom_range(0, 6));
      c_post = int'($urandom_range(0, 6));
      c_slope = int'($urandom_range(0, 1));
      c_force = ($urandom_range(0, 3) == 0) ? 1 : 0;
      q.delete();
      v = c_level + int'($urandom_range(0, 128)) - 64;
      for (int k = 0; k < 30; k++) begin
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        q.push_back(v);
        v = v + int'($urandom_range(0, 40)) - 20;
      end
      run_capture(1);
      check_capture($sformatf("rand%0d", t));
    end

    // reset in the middle of a capture
    c_ch = 2; c_level = 'hFFF; c_pre = 3; c_post = 3; c_slope = 0; c_force = 0;
    q = '{'h10, 'h20};
    run_capture(0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) drive(2, 'h30);
    idle(2);
    check("midreset/writes", wa_q.size(), 2);
    csr_rd(1, rd);
    check("midreset/status", rd, 0);
    csr_rd(2, rd);
    check("midreset/level", rd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Sequences single-shot triggered captures of the modular ADC sample stream into a circular sample RAM inside QsysCore. Configured and armed by the SPI-to-Avalon-MM master through a small CSR slave. Detects a level-crossing trigger on one selected channel, stores pre- and post-trigger samples, and raises `complete` for the external COMPLETE pin.

## Interface
- `DATA_W`, 12: ADC sample width.
- `ADDR_W`, 10: sample RAM address width; depth = 2^ADDR_W.
- `CH_W`, 5: Avalon-ST channel width.

- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `csr_address` in 3: CSR word address.
- `csr_write` / `csr_read` in 1: CSR strobes.
- `csr_writedata` in 32; `csr_readdata` out 32: fixed read latency of 1 cycle.
- `snk_valid` in 1; `snk_channel` in CH_W; `snk_data` in DATA_W: ADC sample stream; no backpressure.
- `mem_we` out 1; `mem_waddr` out ADDR_W; `mem_wdata` out DATA_W: RAM write port.
- `complete` out 1: capture finished.

## Operation
- CSR map:
  - 0 CONTROL (write-only): bit0 ARM, bit1 ABORT, bit2 SLOPE (0 rising, 1 falling), bit3 FORCE.
  - 1 STATUS (read-only): [2:0] state, bit4 complete, bit5 wrapped.
  - 2 TRIG_LEVEL [DATA_W-1:0].
  - 3 TRIG_CHANNEL [CH_W-1:0].
  - 4 PRE_COUNT [ADDR_W-1:0].
  - 5 POST_COUNT [ADDR_W-1:0].
  - 6 TRIG_ADDR (read-only): RAM address of the trigger sample.
  - 7 WR_ADDR (read-only): next write address.
  - Unmapped reads return 0.
- Qualified sample: `snk_valid` with `snk_channel`==TRIG_CHANNEL. All other samples are ignored.
- States and encodings: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4.
- IDLE/DONE + ARM -> PRE:
  - Latch SLOPE, TRIG_LEVEL, TRIG_CHANNEL, PRE_COUNT and POST_COUNT; later CSR writes do not affect the running capture.
  - Clear the write address, wrapped, complete and the FORCE pending flag; invalidate the previous sample.
- PRE: store each qualified sample. After PRE_COUNT samples have been stored -> WAIT_TRIG. PRE_COUNT=0 goes -> WAIT_TRIG on the cycle after ARM.
- WAIT_TRIG:
  - Store each qualified sample.
  - Trigger conditions: rising is prev<LEVEL && cur>=LEVEL; falling is prev>LEVEL && cur<=LEVEL.
  - prev is the previous stored sample, which must be valid; the first stored sample after ARM can never trigger.
  - A pending FORCE makes the next stored sample the trigger.
  - On trigger: TRIG_ADDR = address of that sample -> POST, or -> DONE if POST_COUNT=0.
- POST: store POST_COUNT further qualified samples, then -> DONE.
- DONE: `complete`=1; it stays set until the next ARM, an ABORT or reset.
- ABORT in any state -> IDLE with `complete`=0. When ABORT and ARM are in the same write, ABORT wins.
- ARM while in PRE, WAIT_TRIG or POST is ignored.
- FORCE is accepted only in PRE or WAIT_TRIG. In PRE it is held pending until WAIT_TRIG.
- Write address increments modulo 2^ADDR_W. wrapped is set on the first rollover from 2^ADDR_W-1 to 0; the oldest data is overwritten.

## Timing
- Reset values:
  - state IDLE; `complete`=0; `mem_we`=0; `mem_waddr`=0; `mem_wdata`=0; `csr_readdata`=0.
  - TRIG_LEVEL=0, TRIG_CHANNEL=0, PRE_COUNT=0, POST_COUNT=0, TRIG_ADDR=0.
- `mem_we`/`mem_waddr`/`mem_wdata` are registered: asserted 1 cycle after the qualified `snk_valid`, 1 cycle wide, one write per sample.
- Trigger evaluation uses the same sample that is being written. The state change and TRIG_ADDR update on the same edge as that sample's `mem_we`.
- `complete` rises on the same edge as the final POST write's `mem_we`. For POST_COUNT=0 it rises with the trigger sample's write.
- A CSR write takes effect on the next edge. ARM on cycle N means a qualified sample at cycle N+1 is the first one stored.
- `csr_readdata` is valid on the cycle after `csr_read`.
- A reset mid-capture has priority over every other input. It returns the block to reset values on the next edge, and no further `mem_we` is issued.

## Test plan
- Reset, then read all CSRs -> STATUS=0, regs 2..7=0, `complete`=0, no `mem_we`.
- TRIG_CHANNEL=3, LEVEL=0x800, PRE=4, POST=8, rising; ARM; ramp channel-3 samples 0x7F0 step 4 (0x7FC->0x800 crossing), interleaved with channel 0 noise -> 13 writes to addresses 0..12, TRIG_ADDR=4, `complete` set with write 12.
- Falling slope, LEVEL=0x100, POST=0; samples 0x200,0x180,0x100 -> trigger at the third sample, `complete` rises with the same write, TRIG_ADDR=2.
- PRE=0; FORCE right after ARM with a constant input of 0x555 -> first sample is the trigger, POST=2 -> DONE after 3 writes.
- ADDR_W=4, PRE=20, POST=3, trigger at the 25th sample -> wrapped=1, TRIG_ADDR=(24 mod 16)=8, WR_ADDR=12.
- ABORT during POST after 2 writes -> IDLE, `complete`=0, no further writes. ARM+ABORT in one write -> stays IDLE.
